// File: rtl/nand_seq_pkg.sv
// Shared types and constants for the NAND2 cell self-test sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nand_seq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      APPLY  = 3'd1,
      SETTLE = 3'd2,
      SAMPLE = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Expected cell output indexed by vec = {A,B}: NAND gives 1,1,1,0.
   localparam logic [3:0] EXPECTED_Y = 4'b0111;
   localparam logic [1:0] VEC_LAST   = 2'd3;

endpackage

// File: rtl/nand_seq_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Latency: count visible one clock after inc.
// Backpressure: none; inc is ignored once saturated.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/nand_cell_sequencer.sv
// Steps a NAND2 cell through its truth table, samples Y after a settle hold, counts mismatches.
// Latency: SETTLE_CYCLES+2 clocks per vector; done 4*(SETTLE_CYCLES+2)*loops+1 clocks after start.
// Backpressure: none; start ignored while busy, abort forces DONE from any busy state.
module nand_cell_sequencer
   import nand_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] loops,
   output logic             cell_a,
   output logic             cell_b,
   input  logic             cell_y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [1:0]       first_fail
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   state_t           state;
   logic [1:0]       vec;
   logic [CNT_W-1:0] loops_q;
   logic [CNT_W-1:0] loop_ctr;
   logic [SW-1:0]    settle_ctr;
   logic             in_run;
   logic             mismatch;
   logic             fail_inc;
   logic             fail_clr;

   assign in_run   = (state == APPLY) || (state == SETTLE) || (state == SAMPLE);
   assign mismatch = (cell_y != EXPECTED_Y[vec]);
   assign fail_clr = (state == IDLE) && start;
   // An aborted sample is discarded, so it must not reach the counter.
   assign fail_inc = (state == SAMPLE) && !abort && mismatch;

   sat_counter #(.W(CNT_W)) u_fail_cnt (
      .clk (clk),
      .rst (rst),
      .clr (fail_clr),
      .inc (fail_inc),
      .cnt (fail_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         vec        <= 2'd0;
         loops_q    <= '0;
         loop_ctr   <= '0;
         settle_ctr <= '0;
         cell_a     <= 1'b0;
         cell_b     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         first_fail <= 2'b00;
      end else begin
         done <= 1'b0;
         if (in_run && abort) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            cell_a <= 1'b0;
            cell_b <= 1'b0;
            pass   <= (fail_cnt == '0);
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state      <= APPLY;
                     busy       <= 1'b1;
                     loops_q    <= loops;
                     loop_ctr   <= '0;
                     vec        <= 2'd0;
                     pass       <= 1'b0;
                     first_fail <= 2'b00;
                  end
               end
               APPLY: begin
                  {cell_a, cell_b} <= vec;
                  settle_ctr       <= SW'(SETTLE_CYCLES - 1);
                  state            <= SETTLE;
               end
               SETTLE: begin
                  if (settle_ctr == '0) begin
                     state <= SAMPLE;
                  end else begin
                     settle_ctr <= settle_ctr - SW'(1);
                  end
               end
               SAMPLE: begin
                  // fail_cnt still zero here means this is the run's first mismatch.
                  if (mismatch && (fail_cnt == '0)) begin
                     first_fail <= vec;
                  end
                  if (vec != VEC_LAST) begin
                     vec   <= vec + 2'd1;
                     state <= APPLY;
                  end else begin
                     loop_ctr <= loop_ctr + CNT_W'(1);
                     if ((loops_q != '0) && ((loop_ctr + CNT_W'(1)) == loops_q)) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        cell_a <= 1'b0;
                        cell_b <= 1'b0;
                        pass   <= (fail_cnt == '0) && !mismatch;
                     end else begin
                        vec   <= 2'd0;
                        state <= APPLY;
                     end
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_nand_cell_sequencer.sv
// Directed and randomized runs of the sequencer against a faultable NAND cell model;
// expectations come from truth-table arithmetic over whole runs.
module tb_nand_cell_sequencer;

   localparam int S  = 4;
   localparam int W  = 8;
   localparam int VP = S + 2;       // clocks spent per vector
   localparam int LIMIT = 10000;

   logic         clk = 1'b0;
   logic         rst, start, abort;
   logic [W-1:0] loops;
   logic         cell_a, cell_b, cell_y;
   logic         busy, done, pass;
   logic [W-1:0] fail_cnt;
   logic [1:0]   first_fail;

   int          checks = 0;
   int          errors = 0;
   int          stuck  = 0;        // 0 healthy, 1 stuck-at-1, 2 stuck-at-0
   logic [3:0]  flip   = 4'b0000;  // per-vector output inversion

   nand_cell_sequencer #(.SETTLE_CYCLES(S), .CNT_W(W)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .loops(loops),
      .cell_a(cell_a), .cell_b(cell_b), .cell_y(cell_y),
      .busy(busy), .done(done), .pass(pass),
      .fail_cnt(fail_cnt), .first_fail(first_fail)
   );

   always #5 clk = ~clk;

   function automatic logic cell_model(int st, logic [3:0] fl, logic [1:0] v);
      case (st)
         1:       return 1'b1;
         2:       return 1'b0;
         default: return !(v[1] && v[0]) ^ fl[v];
      endcase
   endfunction

   always_comb cell_y = cell_model(stuck, flip, {cell_a, cell_b});

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Whole-run expectation: per-loop mismatch count times loops, saturated.
   task automatic model_run(input int st, input logic [3:0] fl, input int n,
                            output int fails, output int first, output int pass_e);
      int per = 0;
      first = 0;
      for (int v = 0; v < 4; v++) begin
         logic [1:0] vv;
         logic exp_y;
         vv    = v[1:0];
         exp_y = !(vv[1] && vv[0]);
         if (cell_model(st, fl, vv) !== exp_y) begin
            if (per == 0) first = v;
            per++;
         end
      end
      fails  = per * n;
      if (fails > 255) fails = 255;
      pass_e = (per == 0) ? 1 : 0;
   endtask

   task automatic run_until_done(output int clocks, output int busy_cnt);
      clocks   = 1;
      busy_cnt = busy ? 1 : 0;
      while (!done && clocks < LIMIT) begin
         tick();
         clocks++;
         if (busy) busy_cnt++;
      end
      check("done_seen", done, 1);
   endtask

   task automatic do_run(string tag, int st, logic [3:0] fl, int n);
      int clocks, busy_cnt, ef, efirst, epass;
      stuck = st;
      flip  = fl;
      loops = n[W-1:0];
      start = 1'b1;
      tick();
      start = 1'b0;
      run_until_done(clocks, busy_cnt);
      model_run(st, fl, n, ef, efirst, epass);
      check({tag, "_latency"}, clocks, 4 * VP * n + 1);
      check({tag, "_busy_clocks"}, busy_cnt, 4 * VP * n);
      check({tag, "_fail_cnt"}, fail_cnt, ef);
      check({tag, "_first_fail"}, first_fail, efirst);
      check({tag, "_pass"}, pass, epass);
      tick();
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_fail_hold"}, fail_cnt, ef);
      check({tag, "_pass_hold"}, pass, epass);
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_pass"}, pass, 0);
      check({tag, "_fail_cnt"}, fail_cnt, 0);
      check({tag, "_first_fail"}, first_fail, 0);
      check({tag, "_cell_a"}, cell_a, 0);
      check({tag, "_cell_b"}, cell_b, 0);
   endtask

   initial begin
      int off, k_abort, ef, efirst, seen_done, ev;
      logic [3:0] fl;

      rst = 1'b1; start = 1'b0; abort = 1'b0; loops = '0;
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // Healthy cell, single pass, default latency.
      do_run("t1_good", 0, 4'b0000, 1);
      // Stuck-at-1: only vector 11 fails each loop.
      do_run("t2_stuck1", 1, 4'b0000, 3);
      // Stuck-at-0: three failures per loop, 765 total saturates the counter.
      do_run("t3_stuck0", 2, 4'b0000, 255);

      // Random per-vector inversion faults and loop counts.
      for (int r = 0; r < 4; r++) begin
         do_run("rand_run", 0, 4'($urandom_range(0, 15)), $urandom_range(1, 4));
      end

      // Endless run, abort while in the settle window of the 101st loop.
      stuck = 0; flip = 4'b0000; loops = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      off = $urandom_range(1, S);
      seen_done = 0;
      repeat (4 * VP * 100 + off) begin
         tick();
         if (done) seen_done++;
      end
      check("t4_no_done_loops0", seen_done, 0);
      check("t4_busy_before_abort", busy, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t4_done", done, 1);
      check("t4_busy", busy, 0);
      check("t4_pass", pass, 1);
      check("t4_cell_a", cell_a, 0);
      check("t4_cell_b", cell_b, 0);
      tick();

      // Random abort point against a random fault; only completed samples count.
      fl = 4'($urandom_range(1, 15));
      flip = fl; loops = '0;
      k_abort = $urandom_range(1, 60);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (k_abort - 1) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      ef = 0; efirst = 0;
      for (int j = 1; j * VP < k_abort; j++) begin
         if (fl[(j - 1) % 4]) begin
            if (ef == 0) efirst = (j - 1) % 4;
            ef++;
         end
      end
      check("rand_abort_done", done, 1);
      check("rand_abort_fail_cnt", fail_cnt, ef);
      check("rand_abort_first_fail", first_fail, efirst);
      check("rand_abort_pass", pass, (ef == 0) ? 1 : 0);
      tick();
      flip = 4'b0000;

      // Reset while sampling vector 11 of the second loop with a stuck-at-1 cell.
      stuck = 1; loops = 8'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (8 * VP - 1) tick();
      check("t5_fail_before_rst", fail_cnt, 1);
      check("t5_busy_before_rst", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_outputs("t5_midrun_reset");
      tick();
      do_run("t5_after_rst", 1, 4'b0000, 1);

      // Start held through DONE restarts; a start pulse while busy is ignored.
      stuck = 0; loops = 8'd1;
      start = 1'b1;
      tick();
      begin
         int clocks, busy_cnt;
         run_until_done(clocks, busy_cnt);
         check("t6_first_latency", clocks, 4 * VP + 1);
      end
      tick();
      check("t6_idle_after_done", busy, 0);
      tick();
      check("t6_restart_busy", busy, 1);
      start = 1'b0;
      for (int k = 1; k <= 4 * VP; k++) begin
         start = (k == 10);
         tick();
         ev = (k == 4 * VP) ? 0 : (k - 1) / VP;
         check("t6_ab_sequence", {cell_a, cell_b}, ev);
      end
      start = 1'b0;
      check("t6_second_done", done, 1);
      check("t6_second_pass", pass, 1);
      tick();
      check("t6_no_extra_run", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
